hs_rx_fifo: RTL and testbench

//  Receive-side buffer directly downstream of the valid/ready slave stage in the
//  AXI-style handshake path. Accepts 32-bit words on a valid/ready input channel,

---
 rtl/hs_rx_fifo.sv | 83 ++++++++
 tb/tb_hs_rx_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hs_rx_fifo.sv
// Receive-side FWFT buffer behind the valid/ready slave stage. It counts delivered
// words and flags upstream senders that drop or alter a stalled word.
module hs_rx_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       s_valid,
   input  logic [DATA_W-1:0]          s_data,
   output logic                       s_ready,
   output logic                       m_valid,
   output logic [DATA_W-1:0]          m_data,
   input  logic                       m_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic [CNT_W-1:0]           xfer_cnt,
   output logic                       proto_err,
   input  logic                       clr_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  rd_ptr_next;
   logic              push;
   logic              pop;
   logic [LVL_W-1:0]  level_next;
   logic [LVL_W-1:0]  avail;
   logic              stall_q;
   logic [DATA_W-1:0] stall_data;

   // avail excludes the word being written this edge, which gives the
   // one-cycle fill latency into the registered output stage.
   always_comb begin
      push        = s_valid & s_ready;
      pop         = m_valid & m_ready;
      level_next  = level + LVL_W'(push) - LVL_W'(pop);
      avail       = level - LVL_W'(pop);
      rd_ptr_next = rd_ptr + PTR_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= s_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         s_ready    <= 1'b0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         xfer_cnt   <= '0;
         proto_err  <= 1'b0;
         stall_q    <= 1'b0;
         stall_data <= '0;
      end else begin
         wr_ptr  <= wr_ptr + PTR_W'(push);
         rd_ptr  <= rd_ptr_next;
         level   <= level_next;
         s_ready <= (level_next < LVL_W'(DEPTH));
         m_valid <= (avail != '0);
         if (avail != '0)
            m_data <= mem[rd_ptr_next];
         if (pop)
            xfer_cnt <= xfer_cnt + CNT_W'(1);
         // A stalled word must stay valid and unchanged until accepted.
         stall_q    <= s_valid & ~s_ready;
         stall_data <= s_data;
         if (stall_q && (!s_valid || (s_data != stall_data)))
            proto_err <= 1'b1;
         else if (clr_err)
            proto_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_hs_rx_fifo.sv
// Scoreboard bench for hs_rx_fifo: accepted words are queued at the input
// handshake and compared in order at the output handshake.
module tb_hs_rx_fifo;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        s_valid = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_ready;
   logic        m_valid;
   logic [31:0] m_data;
   logic        m_ready = 1'b0;
   logic [2:0]  level;
   logic [15:0] xfer_cnt;
   logic        proto_err;
   logic        clr_err = 1'b0;

   int          nChecks = 0;
   int          nPass = 0;
   int          modelXfer = 0;
   logic [31:0] sb [$];
   logic [31:0] expWord;

   hs_rx_fifo #(.DATA_W(32), .DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
      .level(level), .xfer_cnt(xfer_cnt), .proto_err(proto_err), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs === exp)
         nPass++;
      else
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Inputs are stable from posedge+1, so the negedge view predicts the next edge.
   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
         modelXfer = 0;
      end else begin
         if (m_valid && m_ready) begin
            if (sb.size() == 0)
               checkOutput("sbUnderflow", 32'(sb.size()), 1);
            else begin
               expWord = sb.pop_front();
               checkOutput("m_data", m_data, expWord);
            end
            modelXfer++;
         end
         if (s_valid && s_ready)
            sb.push_back(s_data);
      end
   end

   task automatic stepIn();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] w);
      logic acc;
      acc = 1'b0;
      s_valid = 1'b1;
      s_data = w;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         acc = s_ready;
         stepIn();
      end
      checkOutput("pushAccepted", {31'b0, acc}, 1);
   endtask

   task automatic applyReset();
      reset = 1'b1;
      s_valid = 1'b0;
      m_ready = 1'b0;
      clr_err = 1'b0;
      repeat (2) stepIn();
      checkOutput("rstSReady", {31'b0, s_ready}, 0);
      checkOutput("rstMValid", {31'b0, m_valid}, 0);
      checkOutput("rstLevel", {29'b0, level}, 0);
      checkOutput("rstMData", m_data, 0);
      checkOutput("rstXfer", {16'b0, xfer_cnt}, 0);
      checkOutput("rstProto", {31'b0, proto_err}, 0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("sReadyBeforeEdge", {31'b0, s_ready}, 0);
      stepIn();
      checkOutput("sReadyAfterRelease", {31'b0, s_ready}, 1);
      checkOutput("idleMValid", {31'b0, m_valid}, 0);
      checkOutput("idleLevel", {29'b0, level}, 0);
   endtask

   task automatic drain();
      logic done;
      done = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         done = (level == 0) && !m_valid;
      end
      stepIn();
      m_ready = 1'b0;
      checkOutput("drainDone", {31'b0, done}, 1);
      checkOutput("drainXfer", {16'b0, xfer_cnt}, 32'(modelXfer % 65536));
      checkOutput("drainSb", 32'(sb.size()), 0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      applyReset();

      // In-order streaming with one-cycle fill latency
      m_ready = 1'b1;
      applyStimulus(32'h11);
      checkOutput("latencyEdgeN", {31'b0, m_valid}, 0);
      applyStimulus(32'h22);
      checkOutput("latencyEdgeN1", {31'b0, m_valid}, 1);
      checkOutput("firstWord", m_data, 32'h11);
      applyStimulus(32'h33);
      s_valid = 1'b0;
      drain();
      checkOutput("xferAfterThree", {16'b0, xfer_cnt}, 3);

      // Fill to full, hold off the fifth word, release one slot
      m_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 5; i++)
               applyStimulus(32'h100 + 32'(i));
            s_valid = 1'b0;
         end
         begin
            repeat (8) stepIn();
            checkOutput("fullSReady", {31'b0, s_ready}, 0);
            checkOutput("fullLevel", {29'b0, level}, 4);
            checkOutput("fullHead", m_data, 32'h100);
            m_ready = 1'b1;
            @(negedge clk);
            checkOutput("sReadyDuringPop", {31'b0, s_ready}, 0);
            stepIn();
            m_ready = 1'b0;
            checkOutput("sReadyAfterPop", {31'b0, s_ready}, 1);
            checkOutput("levelAfterPop", {29'b0, level}, 3);
         end
      join
      checkOutput("fifthAccepted", {29'b0, level}, 4);
      checkOutput("noProtoErr", {31'b0, proto_err}, 0);
      drain();

      // Upstream changes data while stalled
      for (int i = 0; i < 4; i++)
         applyStimulus(32'h200 + 32'(i));
      s_data = 32'hAAAA;
      stepIn();
      checkOutput("stallNoErr", {31'b0, proto_err}, 0);
      s_data = 32'hBBBB;
      @(negedge clk);
      checkOutput("errBeforeEdge", {31'b0, proto_err}, 0);
      stepIn();
      checkOutput("errSet", {31'b0, proto_err}, 1);
      s_valid = 1'b0;
      stepIn();
      clr_err = 1'b1;
      stepIn();
      clr_err = 1'b0;
      checkOutput("errCleared", {31'b0, proto_err}, 0);
      drain();

      // Steady state at level 2 with push and pop every cycle
      applyStimulus(32'h300);
      applyStimulus(32'h301);
      s_valid = 1'b0;
      checkOutput("levelTwo", {29'b0, level}, 2);
      m_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(32'h310 + 32'(i));
         checkOutput("levelSteady", {29'b0, level}, 2);
      end
      s_valid = 1'b0;
      drain();

      // Reset mid-operation discards stored words
      for (int i = 0; i < 3; i++)
         applyStimulus(32'h400 + 32'(i));
      s_valid = 1'b0;
      checkOutput("levelThree", {29'b0, level}, 3);
      reset = 1'b1;
      stepIn();
      checkOutput("midRstLevel", {29'b0, level}, 0);
      checkOutput("midRstMValid", {31'b0, m_valid}, 0);
      checkOutput("midRstXfer", {16'b0, xfer_cnt}, 0);
      reset = 1'b0;
      stepIn();
      checkOutput("postRstSReady", {31'b0, s_ready}, 1);
      m_ready = 1'b1;
      applyStimulus(32'h5A);
      s_valid = 1'b0;
      drain();
      checkOutput("postRstXfer", {16'b0, xfer_cnt}, 1);

      checkOutput("sbLeft", 32'(sb.size()), 0);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
